uart_cmd_seq: RTL and testbench

- Host-side command sequencer. Holds a loadable byte sequence (for example CPU_RST 8'h2a, CONF_WR 8'h2c + 8 bytes, DATA_WR 8'h2e + payload, CPU_RUN 8'h2b) and streams it one byte at a time into a uart_tx instance.
- Sits directly upstream of uart_tx, which feeds the uart_rx/ram_rw loader chain.
- Replaces ad-hoc benches and debug loaders with one synthesizable block that enforces the handshake.

---
 rtl/uart_cmd_seq.sv | 115 +++++++++++
 tb/tb_uart_cmd_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: buffers a loadable byte sequence and streams it into uart_tx under the rdy/vld handshake
module uart_cmd_seq #(
    parameter int DEPTH       = 64,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [7:0]               load_data_i,
    input  logic                     load_vld_i,
    input  logic                     load_clr_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     uart_tx_data_rdy_i,
    output logic [7:0]               uart_tx_data_o,
    output logic                     uart_tx_data_vld_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     load_full_o,
    output logic [$clog2(DEPTH):0]   seq_len_o,
    output logic [$clog2(DEPTH):0]   sent_cnt_o
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int CMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, OFFER, WAIT_ACK, GAP} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [LW-1:0] r_seq_len, r_rd_ptr, r_sent_cnt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_err, r_done, r_abort;
    logic          w_done_nxt, w_ld, w_wr, w_start, w_accept, w_timeout, w_abort, w_full, w_gap_end, w_last;

    // loads are blocked in the start cycle so seq_len cannot change under a starting run
    assign w_ld      = r_state == IDLE && !start_i;
    assign w_full    = r_seq_len == LW'(DEPTH);
    assign w_wr      = w_ld && load_vld_i && !load_clr_i && !w_full;
    assign w_start   = r_state == IDLE && start_i && r_seq_len != '0;
    assign w_abort   = abort_i | r_abort;
    assign w_accept  = r_state == WAIT_ACK && !uart_tx_data_rdy_i;
    assign w_timeout = r_state == WAIT_ACK && uart_tx_data_rdy_i && r_cnt == CW'(ACK_TIMEOUT - 1);
    assign w_gap_end = uart_tx_data_rdy_i && r_cnt == CW'(GAP_CYCLES);
    assign w_last    = r_sent_cnt == r_seq_len || w_abort;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        case (r_state)
            IDLE: begin
                w_state_nxt = w_start ? WAIT_RDY : IDLE;
                w_done_nxt  = start_i && r_seq_len == '0;
            end
            WAIT_RDY: begin
                w_state_nxt = w_abort ? IDLE : uart_tx_data_rdy_i ? OFFER : WAIT_RDY;
                w_done_nxt  = w_abort;
            end
            OFFER: begin
                w_state_nxt = WAIT_ACK;
                w_cnt_nxt   = r_cnt + CW'(1);
            end
            WAIT_ACK: begin
                w_state_nxt = w_accept ? GAP : w_timeout ? IDLE : WAIT_ACK;
                w_done_nxt  = w_timeout;
                w_cnt_nxt   = uart_tx_data_rdy_i ? r_cnt + CW'(1) : '0;
            end
            GAP: begin
                w_state_nxt = !w_gap_end ? GAP : w_last ? IDLE : WAIT_RDY;
                w_done_nxt  = w_gap_end && w_last;
                w_cnt_nxt   = w_gap_end ? '0 : r_cnt + CW'(uart_tx_data_rdy_i);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_abort    <= 1'b0;
            r_seq_len  <= '0;
            r_rd_ptr   <= '0;
            r_sent_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_start ? 1'b0 : r_err | w_timeout;
            r_abort    <= w_state_nxt == IDLE ? 1'b0 : r_abort | (abort_i && r_state != IDLE);
            r_seq_len  <= (w_ld && load_clr_i) ? '0 : r_seq_len + LW'(w_wr);
            r_rd_ptr   <= w_start ? '0 : r_rd_ptr + LW'(w_accept);
            r_sent_cnt <= w_start ? '0 : r_sent_cnt + LW'(w_accept);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_seq_len[AW-1:0]] <= load_data_i;
    end

    // data follows rd_ptr, which only moves once uart_tx has dropped rdy
    assign uart_tx_data_o     = r_state == IDLE ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign uart_tx_data_vld_o = r_state == WAIT_RDY && uart_tx_data_rdy_i && !abort_i;
    assign busy_o             = r_state != IDLE;
    assign done_o             = r_done;
    assign err_o              = r_err;
    assign load_full_o        = w_full;
    assign seq_len_o          = r_seq_len;
    assign sent_cnt_o         = r_sent_cnt;
endmodule

// File: tb/tb_uart_cmd_seq.sv
// tb_uart_cmd_seq: table-driven load-port vectors plus directed runs against a behavioural uart_tx responder
module tb_uart_cmd_seq;
    localparam int DEPTH = 64;
    localparam int TXB   = 10;

    logic       clk = 1'b0;
    logic       rst_n, load_vld, load_clr, start, abort, rdy;
    logic [7:0] load_data;
    logic [7:0] data;
    logic       vld, busy, done, err, full;
    logic [6:0] seq_len, sent_cnt;

    always #5 clk = ~clk;

    uart_cmd_seq #(.DEPTH(DEPTH), .GAP_CYCLES(16), .ACK_TIMEOUT(1024)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .load_data_i(load_data), .load_vld_i(load_vld),
        .load_clr_i(load_clr), .start_i(start), .abort_i(abort), .uart_tx_data_rdy_i(rdy),
        .uart_tx_data_o(data), .uart_tx_data_vld_o(vld), .busy_o(busy), .done_o(done),
        .err_o(err), .load_full_o(full), .seq_len_o(seq_len), .sent_cnt_o(sent_cnt)
    );

    typedef struct {
        logic       clr, wr;
        logic [7:0] d;
        logic       st;
        logic [6:0] len;
        logic       full, busy, done;
    } vec_t;

    int         n_vec = 0, n_err = 0;
    int         cyc = 0, vld_cnt = 0, done_cnt = 0, vld_cyc = 0, done_cyc = 0;
    int         bad_vld = 0, bad_data = 0, left = 0;
    int         b_vld, b_done, b_got;
    logic       stuck = 1'b0, pend = 1'b0, op;
    logic [7:0] last_b;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    vec_t       tbl[8];

    // uart_tx stand-in: rdy drops the cycle after a vld is seen and returns TXB cycles later
    initial begin
        rdy = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend = 1'b0;
                left = 0;
                rdy  = 1'b1;
            end else begin
                op   = pend;
                pend = 1'b0;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (vld) begin
                    if (!rdy) bad_vld++;
                    vld_cnt++;
                    vld_cyc = cyc;
                    last_b  = data;
                    got.push_back(data);
                    pend = !stuck;
                end
                if (op) begin
                    if (data !== last_b) bad_data++;
                    rdy  = 1'b0;
                    left = TXB;
                end else if (left > 0) begin
                    left--;
                    if (left == 0) rdy = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_buf();
        load_clr = 1'b1;
        tick();
        load_clr = 1'b0;
    endtask

    task automatic load_q();
        foreach (exp_q[i]) begin
            load_vld  = 1'b1;
            load_data = exp_q[i];
            tick();
        end
        load_vld = 1'b0;
    endtask

    task automatic kick();
        b_vld  = vld_cnt;
        b_done = done_cnt;
        b_got  = got.size();
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_vld(input int n, input int budget, input string nm);
        int k = 0;
        while (vld_cnt - b_vld < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, vld_cnt - b_vld, n);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int k = 0;
        while (done_cnt == b_done && k < budget) begin
            tick();
            k++;
        end
        tick();
        chk(nm, done_cnt - b_done, 1);
    endtask

    task automatic check_bytes(input int n, input string nm);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", nm, i), (b_got + i < got.size()) ? 32'(got[b_got + i]) : 32'hdead, 32'(exp_q[i]));
    endtask

    initial begin
        rst_n = 1'b0; load_vld = 1'b0; load_clr = 1'b0; start = 1'b0; abort = 1'b0; load_data = 8'h00;
        tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 7'd0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h11, 1'b0, 7'd1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h22, 1'b0, 7'd2, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'h33, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'haa, 1'b0, 7'd1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0};
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_full", full, 0);
        chk("rst_len", seq_len, 0);
        chk("rst_sent", sent_cnt, 0);
        chk("rst_vld", vld, 0);
        chk("rst_data", data, 0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            load_clr = tbl[i].clr; load_vld = tbl[i].wr; load_data = tbl[i].d; start = tbl[i].st;
            tick();
            load_clr = 1'b0; load_vld = 1'b0; start = 1'b0;
            chk($sformatf("tbl%0d_len", i), seq_len, tbl[i].len);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].full);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
        end

        exp_q = '{8'h2a, 8'h2c, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0f, 8'h00, 8'h00, 8'h00,
                  8'h2e, 8'h23, 8'ha0, 8'h84, 8'h00, 8'h0f, 8'h00, 8'hf0, 8'h2b};
        load_q();
        chk("t1_len", seq_len, 19);
        kick();
        wait_done(3000, "t1_done");
        check_bytes(19, "t1_byte");
        chk("t1_sent", sent_cnt, 19);
        chk("t1_vlds", vld_cnt - b_vld, 19);
        chk("t1_err", err, 0);
        chk("t1_busy", busy, 0);

        clear_buf();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(i * 7 + 3));
        load_q();
        load_vld = 1'b1; load_data = 8'hee;
        tick();
        load_vld = 1'b0;
        chk("t2_full", full, 1);
        chk("t2_len", seq_len, 64);
        kick();
        wait_done(6000, "t2_done");
        check_bytes(DEPTH, "t2_byte");
        chk("t2_sent", sent_cnt, 64);
        chk("t2_vlds", vld_cnt - b_vld, 64);

        kick();
        wait_done(6000, "t2b_replay_done");
        chk("t2b_replay_sent", sent_cnt, 64);
        chk("t2b_replay_last", (b_got + 63 < got.size()) ? 32'(got[b_got + 63]) : 32'hdead, 32'(exp_q[63]));

        clear_buf();
        exp_q = '{8'h2a, 8'h2b};
        load_q();
        stuck = 1'b1;
        kick();
        wait_done(3000, "t3_done");
        chk("t3_err", err, 1);
        chk("t3_sent", sent_cnt, 0);
        chk("t3_vlds", vld_cnt - b_vld, 1);
        chk("t3_latency", done_cyc - vld_cyc, 1025);
        stuck = 1'b0;

        clear_buf();
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'h40 + i));
        load_q();
        kick();
        chk("t4_err_clr", err, 0);
        wait_vld(4, 2000, "t4_reach4");
        tick(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(2000, "t4_done");
        tick(60);
        chk("t4_sent", sent_cnt, 4);
        chk("t4_vlds", vld_cnt - b_vld, 4);
        check_bytes(4, "t4_byte");

        clear_buf();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        load_q();
        kick();
        wait_vld(2, 2000, "t6_reach2");
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(2000, "t6_done");
        chk("t6_sent", sent_cnt, 5);
        chk("t6_vlds", vld_cnt - b_vld, 5);
        check_bytes(5, "t6_byte");

        clear_buf();
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'h80 + i));
        load_q();
        kick();
        wait_vld(6, 3000, "t5_reach6");
        chk("t5_vld_pre", vld, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_vld_async", vld, 0);
        chk("t5_busy_async", busy, 0);
        tick(3);
        rst_n = 1'b1;
        tick();
        chk("t5_len", seq_len, 0);
        chk("t5_sent", sent_cnt, 0);
        chk("t5_full", full, 0);
        kick();
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        tick(30);
        chk("t5_vlds", vld_cnt - b_vld, 0);
        chk("t5_dones", done_cnt - b_done, 1);

        chk("vld_while_rdy_low", bad_vld, 0);
        chk("data_unstable", bad_data, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
